// File: rtl/pipe_mult_pkg.sv
// Shared definitions for the pipelined K-bit-per-stage shift-add multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default widths, stage-count derivation, default-width stage record.
package pipe_mult_pkg;

  localparam int W_DEF  = 16;  // operand width
  localparam int K_DEF  = 4;   // multiplier bits retired per stage
  localparam int TW_DEF = 4;   // tag width

  // Number of arithmetic stages; callers must ensure w is a multiple of k.
  function automatic int calc_stages(input int w, input int k);
    return w / k;
  endfunction

  // Pipeline stage record for the default configuration. Modules built with
  // other widths declare a record with exactly this field order and widths
  // scaled from their own parameters.
  typedef struct packed {
    logic [2*W_DEF-1:0] acc;    // running magnitude product
    logic [W_DEF-1:0]   md;     // multiplicand magnitude
    logic [W_DEF-1:0]   mr;     // multiplier bits not yet retired (LSB first)
    logic               neg;    // final product must be negated
    logic [TW_DEF-1:0]  tag;    // opaque passthrough
    logic               valid;  // record holds a live transaction
  } stage_rec_t;

endpackage

// File: rtl/pipe_mult_stage.sv
// One arithmetic stage: adds md * (low K bits of mr) << K*(IDX-1) to acc.
// Latency: 1 cycle when en=1; the final stage also negates when neg=1.
// Backpressure: en=0 holds the register contents unchanged.
// Ports: clk, rst (sync, active-high), en (advance), d (previous stage), q (this stage).
module pipe_mult_stage
  import pipe_mult_pkg::*;
#(
  parameter int  W    = W_DEF,
  parameter int  K    = K_DEF,
  parameter int  TW   = TW_DEF,
  parameter int  IDX  = 1,
  parameter bit  LAST = 1'b0,
  parameter type stage_t = stage_rec_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  stage_t d,
  output stage_t q
);

  localparam int SH = K * (IDX - 1);

  logic [2*W-1:0] pp;
  logic [2*W-1:0] sum;
  stage_t         nxt;

  // mr is shifted right by K every stage, so the slice owned by this stage
  // is always the bottom K bits. The partial product is bounded by
  // (2^W-1)*(2^K-1) << SH, and the running total never exceeds
  // (2^W-1)^2, so 2W bits cannot overflow.
  always_comb begin
    pp  = (2*W)'(d.md) * (2*W)'(d.mr[K-1:0]);
    sum = d.acc + (pp << SH);
    if (LAST && d.neg) begin
      sum = -sum;
    end
    nxt     = d;
    nxt.acc = sum;
    nxt.mr  = d.mr >> K;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/pipe_mult_seq.sv
// Fully pipelined signed/unsigned shift-add multiplier retiring K bits per stage.
// Latency: S+1 edges from acceptance to out_valid (S = W/K); one result per cycle.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, in_md, in_mr, in_signed,
//        in_tag; out_valid/out_ready, out_prod (2W), out_tag.
module pipe_mult_seq
  import pipe_mult_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int K  = K_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_md,
  input  logic [W-1:0]  in_mr,
  input  logic          in_signed,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*W-1:0] out_prod,
  output logic [TW-1:0] out_tag
);

  localparam int S = calc_stages(W, K);

  if ((W % K) != 0) begin : g_bad_k
    $error("pipe_mult_seq: W must be a multiple of K");
  end

  typedef struct packed {
    logic [2*W-1:0] acc;
    logic [W-1:0]   md;
    logic [W-1:0]   mr;
    logic           neg;
    logic [TW-1:0]  tag;
    logic           valid;
  } stage_t;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1),
  // which is still representable as a W-bit unsigned number.
  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic sgn);
    return (sgn && v[W-1]) ? -v : v;
  endfunction

  logic   adv;
  stage_t s0_d;
  stage_t s0_q;
  stage_t stg [0:S];

  // A single global enable: the whole pipe moves only when the output slot
  // is empty or being drained. Bubbles are carried, not squeezed out.
  assign adv      = !out_valid || out_ready;
  assign in_ready = !rst && adv;

  always_comb begin
    s0_d       = '0;
    s0_d.md    = mag(in_md, in_signed);
    s0_d.mr    = mag(in_mr, in_signed);
    s0_d.neg   = in_signed & (in_md[W-1] ^ in_mr[W-1]);
    s0_d.tag   = in_tag;
    s0_d.valid = in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= '0;
    end else if (adv) begin
      s0_q <= s0_d;
    end
  end

  assign stg[0] = s0_q;

  for (genvar i = 1; i <= S; i++) begin : g_stage
    pipe_mult_stage #(
      .W      (W),
      .K      (K),
      .TW     (TW),
      .IDX    (i),
      .LAST   (i == S),
      .stage_t(stage_t)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .en (adv),
      .d  (stg[i-1]),
      .q  (stg[i])
    );
  end

  assign out_valid = stg[S].valid;
  assign out_prod  = stg[S].acc;
  assign out_tag   = stg[S].tag;

  // Operand fields are spent by the final stage.
  logic unused_fin;
  assign unused_fin = ^{stg[S].md, stg[S].mr, stg[S].neg};

endmodule

// File: tb/tb_pipe_mult_seq.sv
module tb_pipe_mult_seq;

  localparam int W   = 16;
  localparam int K   = 4;
  localparam int TW  = 4;
  localparam int W8  = 8;
  localparam int K8  = 2;
  localparam int TW8 = 2;
  localparam int LAT = 5;

  logic clk;
  logic rst;

  logic            a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready;
  logic [W-1:0]    a_in_md, a_in_mr;
  logic [TW-1:0]   a_in_tag, a_out_tag;
  logic [2*W-1:0]  a_out_prod;

  logic            b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
  logic [W8-1:0]   b_in_md, b_in_mr;
  logic [TW8-1:0]  b_in_tag, b_out_tag;
  logic [2*W8-1:0] b_out_prod;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { longint prod; int tag; int cyc; } pend_t;
  typedef struct {
    longint exp_prod; int exp_tag; int acc_cyc;
    longint got_prod; int got_tag; int pop_cyc;
  } rec_t;

  pend_t a_pend[$], b_pend[$];
  rec_t  a_got[$],  b_got[$];

  pipe_mult_seq #(.W(W), .K(K), .TW(TW)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_md(a_in_md), .in_mr(a_in_mr),
    .in_signed(a_in_signed), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_prod(a_out_prod), .out_tag(a_out_tag)
  );

  pipe_mult_seq #(.W(W8), .K(K8), .TW(TW8)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_md(b_in_md), .in_mr(b_in_mr),
    .in_signed(b_in_signed), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_prod(b_out_prod), .out_tag(b_out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret operands as integers, multiply, keep 2w bits.
  function automatic longint ref_prod(input longint md, input longint mr, input int w, input bit sgn);
    longint a, b, m;
    a = md;
    b = mr;
    if (sgn && a[w-1]) a = a - (longint'(1) << w);
    if (sgn && b[w-1]) b = b - (longint'(1) << w);
    m = (longint'(1) << (2*w)) - 1;
    return (a * b) & m;
  endfunction

  // Collector: records accepted operands (with model result) and delivered
  // results, pairing them in FIFO order. Reset discards everything in flight.
  always @(negedge clk) begin
    pend_t p;
    rec_t  r;
    cyc++;
    if (rst) begin
      a_pend.delete();
      b_pend.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (a_pend.size() > 0) p = a_pend.pop_front(); else p = '{-1, -1, -1};
        r = '{p.prod, p.tag, p.cyc, longint'(a_out_prod), int'(a_out_tag), cyc};
        a_got.push_back(r);
      end
      if (a_in_valid && a_in_ready)
        a_pend.push_back('{ref_prod(longint'(a_in_md), longint'(a_in_mr), W, a_in_signed), int'(a_in_tag), cyc});
      if (b_out_valid && b_out_ready) begin
        if (b_pend.size() > 0) p = b_pend.pop_front(); else p = '{-1, -1, -1};
        r = '{p.prod, p.tag, p.cyc, longint'(b_out_prod), int'(b_out_tag), cyc};
        b_got.push_back(r);
      end
      if (b_in_valid && b_in_ready)
        b_pend.push_back('{ref_prod(longint'(b_in_md), longint'(b_in_mr), W8, b_in_signed), int'(b_in_tag), cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (a_got.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_b(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (b_got.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 1'b1; a_in_md = 16'hFFFF; a_in_mr = 16'h1234; a_in_signed = 1'b0; a_in_tag = 4'hA;
    b_in_valid = 1'b1; b_in_md = 8'hFF; b_in_mr = 8'h12; b_in_signed = 1'b1; b_in_tag = 2'd1;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    repeat (3) tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid: got %b want 0", a_out_valid); end
    checks++; if (a_out_prod !== '0) begin errors++; $display("FAIL reset_a_out_prod: got %h want 0", a_out_prod); end
    checks++; if (a_out_tag !== '0) begin errors++; $display("FAIL reset_a_out_tag: got %h want 0", a_out_tag); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_a_in_ready: got %b want 0", a_in_ready); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid: got %b want 0", b_out_valid); end
    checks++; if (b_out_prod !== '0) begin errors++; $display("FAIL reset_b_out_prod: got %h want 0", b_out_prod); end
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL reset_b_in_ready: got %b want 0", b_in_ready); end
    rst = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_a_in_ready: got %b want 1", a_in_ready); end
    tick();
  endtask

  task automatic test_unsigned_latency();
    bit ok;
    rec_t r;
    a_in_valid = 1'b1; a_in_md = 16'hFFFF; a_in_mr = 16'hFFFF; a_in_signed = 1'b0; a_in_tag = 4'd3;
    a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    wait_a(1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL unsigned_timeout: got %0d results want 1", a_got.size());
    end else begin
      r = a_got.pop_front();
      checks++; if (r.got_prod != 64'hFFFE0001) begin errors++; $display("FAIL unsigned_prod: got %h want fffe0001", r.got_prod); end
      checks++; if (r.got_tag != 3) begin errors++; $display("FAIL unsigned_tag: got %0d want 3", r.got_tag); end
      checks++; if (r.pop_cyc - r.acc_cyc != LAT) begin errors++; $display("FAIL unsigned_latency: got %0d want %0d", r.pop_cyc - r.acc_cyc, LAT); end
    end
    repeat (3) tick();
    checks++; if (a_got.size() != 0) begin errors++; $display("FAIL unsigned_extra: got %0d extra results want 0", a_got.size()); end
  endtask

  task automatic test_signed_corners();
    logic [15:0] smd [4];
    logic [15:0] smr [4];
    logic [31:0] sp  [4];
    bit ok;
    rec_t r;
    smd = '{16'h8000, 16'h8000, 16'hFFFF, 16'h7FFF};
    smr = '{16'h8000, 16'h0001, 16'hFFFF, 16'h8000};
    sp  = '{32'h40000000, 32'hFFFF8000, 32'h00000001, 32'hC0008000};
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in_md = smd[i]; a_in_mr = smr[i]; a_in_signed = 1'b1; a_in_tag = 4'(i + 4);
      tick();
    end
    a_in_valid = 1'b0;
    wait_a(4, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL signed_timeout: got %0d results want 4", a_got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        r = a_got.pop_front();
        checks++; if (r.got_prod != longint'(sp[i])) begin errors++; $display("FAIL signed_prod[%0d]: got %h want %h", i, r.got_prod, sp[i]); end
        checks++; if (r.got_tag != i + 4) begin errors++; $display("FAIL signed_tag[%0d]: got %0d want %0d", i, r.got_tag, i + 4); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    rec_t r;
    int prev;
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1; a_in_md = 16'($urandom); a_in_mr = 16'($urandom);
      a_in_signed = 1'(i % 2); a_in_tag = 4'(i);
      tick();
    end
    a_in_valid = 1'b0;
    wait_a(8, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_timeout: got %0d results want 8", a_got.size());
    end else begin
      prev = 0;
      for (int i = 0; i < 8; i++) begin
        r = a_got.pop_front();
        checks++; if (r.got_prod != r.exp_prod) begin errors++; $display("FAIL b2b_prod[%0d]: got %h want %h", i, r.got_prod, r.exp_prod); end
        checks++; if (r.got_tag != i) begin errors++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", i, r.got_tag, i); end
        checks++; if (r.pop_cyc - r.acc_cyc != LAT) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, r.pop_cyc - r.acc_cyc, LAT); end
        if (i > 0) begin
          checks++; if (r.pop_cyc != prev + 1) begin errors++; $display("FAIL b2b_gap[%0d]: got cycle %0d want %0d", i, r.pop_cyc, prev + 1); end
        end
        prev = r.pop_cyc;
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit acc;
    int sent;
    rec_t r;
    logic [31:0] hold_prod;
    logic [3:0]  hold_tag;
    sent = 0;
    acc = 1'b1;
    hold_prod = '0;
    hold_tag = '0;
    for (int c = 0; c < 40 && sent < 14; c++) begin
      if (acc) begin
        a_in_md = 16'($urandom); a_in_mr = 16'($urandom);
        a_in_signed = 1'($urandom_range(0, 1)); a_in_tag = 4'(sent);
      end
      a_in_valid = 1'b1;
      a_out_ready = (c >= 8 && c <= 10) ? 1'b0 : 1'b1;
      #1;
      if (c >= 8 && c <= 10) begin
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[c%0d]: got %b want 0", c, a_in_ready); end
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[c%0d]: got %b want 1", c, a_out_valid); end
        if (c == 8) begin
          hold_prod = a_out_prod;
          hold_tag = a_out_tag;
        end else begin
          checks++; if (a_out_prod !== hold_prod) begin errors++; $display("FAIL bp_prod_stable[c%0d]: got %h want %h", c, a_out_prod, hold_prod); end
          checks++; if (a_out_tag !== hold_tag) begin errors++; $display("FAIL bp_tag_stable[c%0d]: got %h want %h", c, a_out_tag, hold_tag); end
        end
      end
      acc = a_in_valid && a_in_ready;
      if (acc) sent++;
      tick();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    checks++; if (sent != 14) begin errors++; $display("FAIL bp_sent: got %0d want 14", sent); end
    wait_a(14, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bp_timeout: got %0d results want 14", a_got.size());
    end else begin
      for (int i = 0; i < 14; i++) begin
        r = a_got.pop_front();
        checks++; if (r.got_prod != r.exp_prod) begin errors++; $display("FAIL bp_prod[%0d]: got %h want %h", i, r.got_prod, r.exp_prod); end
        checks++; if (r.got_tag != i) begin errors++; $display("FAIL bp_tag[%0d]: got %0d want %0d", i, r.got_tag, i); end
      end
    end
    repeat (8) tick();
    checks++; if (a_got.size() != 0) begin errors++; $display("FAIL bp_duplicates: got %0d extra results want 0", a_got.size()); end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    bit seen;
    rec_t r;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_md = 16'($urandom); a_in_mr = 16'($urandom);
      a_in_signed = 1'($urandom_range(0, 1)); a_in_tag = 4'(i);
      tick();
    end
    a_in_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", a_out_valid); end
    checks++; if (a_out_prod !== '0) begin errors++; $display("FAIL midrst_out_prod: got %h want 0", a_out_prod); end
    checks++; if (a_out_tag !== '0) begin errors++; $display("FAIL midrst_out_tag: got %h want 0", a_out_tag); end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen || a_got.size() != 0) begin errors++; $display("FAIL midrst_stale: got valid=%b results=%0d want none", seen, a_got.size()); end
    a_in_valid = 1'b1; a_in_md = 16'hFFFD; a_in_mr = 16'h0007; a_in_signed = 1'b1; a_in_tag = 4'd9;
    tick();
    a_in_valid = 1'b0;
    wait_a(1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL midrst_fresh_timeout: got %0d results want 1", a_got.size());
    end else begin
      r = a_got.pop_front();
      checks++; if (r.got_prod != 64'hFFFFFFEB) begin errors++; $display("FAIL midrst_fresh_prod: got %h want ffffffeb", r.got_prod); end
      checks++; if (r.got_tag != 9) begin errors++; $display("FAIL midrst_fresh_tag: got %0d want 9", r.got_tag); end
      checks++; if (r.pop_cyc - r.acc_cyc != LAT) begin errors++; $display("FAIL midrst_fresh_latency: got %0d want %0d", r.pop_cyc - r.acc_cyc, LAT); end
    end
  endtask

  task automatic test_param_w8();
    bit ok;
    bit acc;
    int sent;
    rec_t r;
    b_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b_in_valid = 1'b1;
      if (i == 0) begin
        b_in_md = 8'h80; b_in_mr = 8'h80; b_in_signed = 1'b1;
      end else begin
        b_in_md = 8'($urandom); b_in_mr = 8'($urandom); b_in_signed = 1'($urandom_range(0, 1));
      end
      b_in_tag = 2'(i);
      tick();
    end
    b_in_valid = 1'b0;
    wait_b(10, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL w8_timeout: got %0d results want 10", b_got.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        r = b_got.pop_front();
        if (i == 0) begin
          checks++; if (r.got_prod != 64'h4000) begin errors++; $display("FAIL w8_minneg_sq: got %h want 4000", r.got_prod); end
        end
        checks++; if (r.got_prod != r.exp_prod) begin errors++; $display("FAIL w8_prod[%0d]: got %h want %h", i, r.got_prod, r.exp_prod); end
        checks++; if (r.got_tag != i % 4) begin errors++; $display("FAIL w8_tag[%0d]: got %0d want %0d", i, r.got_tag, i % 4); end
        checks++; if (r.pop_cyc - r.acc_cyc != LAT) begin errors++; $display("FAIL w8_latency[%0d]: got %0d want %0d", i, r.pop_cyc - r.acc_cyc, LAT); end
      end
    end
    sent = 0;
    acc = 1'b1;
    for (int c = 0; c < 2000 && sent < 40; c++) begin
      if (acc) begin
        b_in_md = 8'($urandom); b_in_mr = 8'($urandom);
        b_in_signed = 1'($urandom_range(0, 1)); b_in_tag = 2'(sent);
      end
      b_in_valid = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = b_in_valid && b_in_ready;
      if (acc) sent++;
      tick();
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    checks++; if (sent != 40) begin errors++; $display("FAIL w8_rand_sent: got %0d want 40", sent); end
    wait_b(40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL w8_rand_timeout: got %0d results want 40", b_got.size());
    end else begin
      for (int i = 0; i < 40; i++) begin
        r = b_got.pop_front();
        checks++; if (r.got_prod != r.exp_prod) begin errors++; $display("FAIL w8_rand_prod[%0d]: got %h want %h", i, r.got_prod, r.exp_prod); end
        checks++; if (r.got_tag != i % 4) begin errors++; $display("FAIL w8_rand_tag[%0d]: got %0d want %0d", i, r.got_tag, i % 4); end
      end
    end
    repeat (8) tick();
    checks++; if (b_got.size() != 0) begin errors++; $display("FAIL w8_rand_extra: got %0d extra results want 0", b_got.size()); end
  endtask

  initial begin
    test_reset();
    test_unsigned_latency();
    test_signed_corners();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_param_w8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_mult_seq.md
Name: pipe_mult_seq

Overview:
- Parametrised, fully pipelined shift-add multiplier. It is the next generation of the single-bit shift-add stage.
- Each pipeline stage retires K multiplier bits instead of one. The block adds per-transaction signed/unsigned mode, a valid/ready handshake with backpressure, and a tag passthrough.
- Sits between operand-issue logic and result consumers in the multiplication datapath. Accepts one product per cycle.

Parameters:
- W, 16, operand width in bits (multiplicand and multiplier).
- K, 4, multiplier bits retired per stage; W mod K must be 0, checked at elaboration.
- TW, 4, tag width in bits.
- Derived constant S = W/K, the number of arithmetic stages.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept this cycle
- in_md  in  W  multiplicand
- in_mr  in  W  multiplier
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_tag  in  TW  opaque tag, returned with the result
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_prod  out  2W  product
- out_tag  out  TW  tag of this product

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst is high at a rising edge:
  - every stage valid clears, so out_valid=0;
  - out_prod=0 and out_tag=0;
  - all partial-product, multiplicand, multiplier and sign registers clear to 0.
- in_ready is forced to 0 while rst is high. Inputs are ignored during reset. Reset mid-operation discards every in-flight transaction with no output.
- Handshake:
  - Accept when in_valid && in_ready at a rising edge.
  - Global stall: in_ready = !rst && (!out_valid || out_ready).
  - When stalled (out_valid && !out_ready), every pipeline register holds. out_prod and out_tag stay stable until the handshake completes.
  - Bubbles are not compressed; a stage's valid bit travels with its data.
- Pipeline:
  - Stage 0 is the input register. It captures |md| and |mr| as W-bit unsigned magnitudes, plus the result sign neg = in_signed & (md[W-1] ^ mr[W-1]), and the tag.
  - Magnitude of the most-negative value is 2^(W-1) and fits in W unsigned bits.
  - Stages 1..S each hold a 2W-bit accumulator, the multiplicand, the remaining multiplier bits, neg, tag and valid.
  - Stage i adds md * mr_slice_i << (K*(i-1)) to the accumulator, with no overflow possible in 2W bits. mr_slice_i is the K-bit multiplier slice.
  - Stage S additionally applies two's-complement negation to the accumulator when neg=1. Its registers drive out_prod, out_tag and out_valid directly.
- Latency and throughput:
  - Latency is S+1 rising edges, counting the accepting edge as the first. For the defaults, acceptance at edge n gives out_valid=1 after edge n+4.
  - Throughput is 1 result per cycle when out_ready=1.
- Arithmetic:
  - Unsigned mode gives the exact 2W-bit product.
  - Signed mode gives the exact 2W-bit two's-complement product, including (-2^(W-1))^2 = 2^(2W-2).
- Simultaneous events:
  - Accept and output handshake in the same cycle is legal and is the steady state.
  - out_ready rising while stalled releases the pipeline at the next edge.
  - rst has priority over everything.
- The tag is never interpreted. Ordering is strictly FIFO: results leave in acceptance order.

Decomposition:
- Shared package pipe_mult_pkg holds:
  - default W, K and TW;
  - the S derivation function;
  - the stage record typedef (acc[2W], md[W], mr[W], neg, tag[TW], valid).
- One natural sub-module, pipe_mult_stage:
  - parametrised by stage index and final-stage flag;
  - performs the K-bit slice add and the optional negation, with a hold-enable input.
  - The top instantiates S copies in a generate loop plus the input register and handshake logic.

Test Plan:
- Unsigned, W=16 K=4: 0xFFFF*0xFFFF tag=3 -> out_prod=0xFFFE0001, out_tag=3, out_valid exactly 5 edges after acceptance (counting acceptance edge).
- Signed corner cases:
  - 0x8000*0x8000 -> 0x40000000
  - 0x8000*0x0001 -> 0xFFFF8000
  - 0xFFFF*0xFFFF -> 0x00000001
  - 0x7FFF*0x8000 -> 0xC0008000
- Back-to-back: 8 consecutive transactions with tags 0..7 and mixed modes, out_ready=1 -> 8 consecutive out_valid cycles with correct products in tag order.
- Backpressure: out_ready=0 for 3 cycles during a full pipeline -> in_ready=0 and out_prod/out_tag stable for those cycles. After release, all results arrive once each, none dropped or duplicated.
- Reset mid-flight: rst=1 for one cycle with 3 transactions in flight -> out_valid=0 and out_prod=0 next cycle. No stale result ever appears, and a fresh transaction afterwards has normal latency.
- Re-parametrised W=8 K=2 TW=2: random signed/unsigned operands versus a reference model -> all products match, and latency is 5 edges.
